// File: rtl/cheshire_rt_profile_sel.sv
// rtl/cheshire_rt_profile_sel.sv - runtime AXI RT budget/period profile selector with quiesce handshake
// Optional quiesce-ack timeout enabled by defining CHESHIRE_RT_PROFILE_TIMEOUT_EN.
module cheshire_rt_profile_sel #(
    parameter int unsigned NumProfiles    = 2,
    parameter int unsigned NumMgr         = 2,
    parameter int unsigned BudgetWidth    = 32,
    parameter int unsigned PeriodWidth    = 32,
    parameter int unsigned DefaultProfile = 0,
    parameter int unsigned TimeoutCycles  = 1024,
    localparam int unsigned IdxW = (NumProfiles > 1) ? $clog2(NumProfiles) : 1,
    localparam int unsigned MgrW = (NumMgr > 1) ? $clog2(NumMgr) : 1
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          wr_valid_i,
    output logic                          wr_ready_o,
    input  logic [IdxW-1:0]               wr_profile_i,
    input  logic [MgrW-1:0]               wr_mgr_i,
    input  logic [BudgetWidth-1:0]        wr_budget_i,
    input  logic [PeriodWidth-1:0]        wr_period_i,
    input  logic                          sel_valid_i,
    output logic                          sel_ready_o,
    input  logic [IdxW-1:0]               sel_profile_i,
    output logic                          quiesce_req_o,
    input  logic                          quiesce_ack_i,
    output logic [IdxW-1:0]               active_profile_o,
    output logic [NumMgr*BudgetWidth-1:0] budget_o,
    output logic [NumMgr*PeriodWidth-1:0] period_o,
    output logic                          cfg_update_o,
    output logic                          done_o,
    output logic                          err_o,
    output logic                          busy_o
);

    if (NumProfiles < 1 || NumMgr < 1 || DefaultProfile >= NumProfiles || TimeoutCycles < 1) begin : g_bad_params
        $error("cheshire_rt_profile_sel: illegal parameter combination");
    end

    typedef enum logic [1:0] {
        S_IDLE,
        S_QUIESCE,
        S_APPLY,
        S_RELEASE
    } state_e;

    localparam logic [IdxW:0] NumProfilesW = (IdxW+1)'(NumProfiles);
    localparam logic [MgrW:0] NumMgrW      = (MgrW+1)'(NumMgr);

    state_e                          r_state;
    logic [IdxW-1:0]                 r_target;
    logic [IdxW-1:0]                 r_active;
    logic [BudgetWidth-1:0]          r_budget_tbl [NumProfiles][NumMgr];
    logic [PeriodWidth-1:0]          r_period_tbl [NumProfiles][NumMgr];
    logic [NumMgr*BudgetWidth-1:0]   r_budget;
    logic [NumMgr*PeriodWidth-1:0]   r_period;
    logic                            r_cfg_update;
    logic                            r_done;
    logic                            r_err;
    logic                            r_qreq;
    logic                            r_busy;
    logic                            r_sel_ready;
    logic                            r_wr_ready;

    state_e                          w_state_nxt;
    logic                            w_wr_accept;
    logic                            w_wr_invalid;
    logic                            w_sel_invalid;
    logic                            w_sel_done;
    logic                            w_sel_err;
    logic                            w_sel_switch;
    logic                            w_rel_done;
    logic                            w_timeout;

    assign w_wr_accept   = wr_valid_i && r_wr_ready;
    assign w_wr_invalid  = ({1'b0, wr_profile_i} >= NumProfilesW) || ({1'b0, wr_mgr_i} >= NumMgrW);
    assign w_sel_invalid = {1'b0, sel_profile_i} >= NumProfilesW;

`ifdef CHESHIRE_RT_PROFILE_TIMEOUT_EN
    localparam int unsigned CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;

    logic [CntW-1:0] r_cnt;

    // Counts cycles spent in QUIESCE; zero everywhere else so each entry starts fresh.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt <= '0;
        end else if (r_state == S_QUIESCE) begin
            r_cnt <= r_cnt + CntW'(1);
        end else begin
            r_cnt <= '0;
        end
    end
`endif

    always_comb begin
        w_state_nxt  = r_state;
        w_sel_done   = 1'b0;
        w_sel_err    = 1'b0;
        w_sel_switch = 1'b0;
        w_rel_done   = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (sel_valid_i) begin
                    if (w_sel_invalid) begin
                        w_sel_err = 1'b1;
                    end else if (sel_profile_i == r_active) begin
                        w_sel_done = 1'b1;
                    end else begin
                        w_sel_switch = 1'b1;
                        w_state_nxt  = S_QUIESCE;
                    end
                end
            end
            S_QUIESCE: begin
                if (quiesce_ack_i) begin
                    w_state_nxt = S_APPLY;
`ifdef CHESHIRE_RT_PROFILE_TIMEOUT_EN
                end else if (r_cnt == CntW'(TimeoutCycles - 1)) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_IDLE;
`endif
                end
            end
            S_APPLY: begin
                w_state_nxt = S_RELEASE;
            end
            S_RELEASE: begin
                if (!quiesce_ack_i) begin
                    w_rel_done  = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Shadow table: writes land here and reach the outputs only through APPLY.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int p = 0; p < NumProfiles; p++) begin
                for (int m = 0; m < NumMgr; m++) begin
                    r_budget_tbl[p][m] <= '0;
                    r_period_tbl[p][m] <= '0;
                end
            end
        end else if (w_wr_accept && !w_wr_invalid) begin
            r_budget_tbl[wr_profile_i][wr_mgr_i] <= wr_budget_i;
            r_period_tbl[wr_profile_i][wr_mgr_i] <= wr_period_i;
        end
    end

    // Status outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_IDLE;
            r_target     <= IdxW'(DefaultProfile);
            r_active     <= IdxW'(DefaultProfile);
            r_budget     <= '0;
            r_period     <= '0;
            r_cfg_update <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_qreq       <= 1'b0;
            r_busy       <= 1'b0;
            r_sel_ready  <= 1'b1;
            r_wr_ready   <= 1'b1;
        end else begin
            r_state      <= w_state_nxt;
            r_qreq       <= (w_state_nxt == S_QUIESCE) || (w_state_nxt == S_APPLY);
            r_busy       <= (w_state_nxt != S_IDLE);
            r_sel_ready  <= (w_state_nxt == S_IDLE);
            r_wr_ready   <= (w_state_nxt != S_APPLY);
            r_done       <= w_sel_done || w_rel_done;
            r_err        <= w_sel_err || w_timeout || (w_wr_accept && w_wr_invalid);
            r_cfg_update <= (r_state == S_APPLY);
            if (w_sel_switch) begin
                r_target <= sel_profile_i;
            end
            // Sampled at the end of APPLY so a write accepted on the QUIESCE->APPLY edge is included.
            if (r_state == S_APPLY) begin
                r_active <= r_target;
                for (int m = 0; m < NumMgr; m++) begin
                    r_budget[m*BudgetWidth +: BudgetWidth] <= r_budget_tbl[r_target][m];
                    r_period[m*PeriodWidth +: PeriodWidth] <= r_period_tbl[r_target][m];
                end
            end
        end
    end

    assign wr_ready_o       = r_wr_ready;
    assign sel_ready_o      = r_sel_ready;
    assign quiesce_req_o    = r_qreq;
    assign active_profile_o = r_active;
    assign budget_o         = r_budget;
    assign period_o         = r_period;
    assign cfg_update_o     = r_cfg_update;
    assign done_o           = r_done;
    assign err_o            = r_err;
    assign busy_o           = r_busy;

endmodule
